// File: rtl/slave_pkg.sv
// Shared definitions for the Chip2Chip slave handshake controller:
// FSM state encoding and default parameter values.
package slave_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_CNT     = 2'd1,
        SEND_ACK     = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W         = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for a level arriving from another clock domain.
// Both flops clear asynchronously to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/slave_control.sv
// Chip2Chip slave handshake: request -> one-second notice -> ack -> data latch.
// Optional SEND_ACK watchdog with sticky err, enabled by defining SLAVE_TIMEOUT_EN.
module slave_control
    import slave_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              done,
    output logic              start,
    output logic              ack,
    output logic              notice,
    output logic [DATA_W-1:0] data_out,
    output logic              err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic              w_req_s;
    logic              w_valid_s;
    logic              w_timeout;
    state_t            r_state;
    logic [DATA_W-1:0] r_data;

    sync_2ff u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (request),
        .q     (w_req_s)
    );

    sync_2ff u_sync_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (valid),
        .q     (w_valid_s)
    );

`ifdef SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_waiting;

    // Counting only while SEND_ACK is neither left by abort nor by latch.
    assign w_waiting = (r_state == SEND_ACK) && w_req_s && !w_valid_s;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_waiting && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_waiting && w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_s) r_state <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    if (!w_req_s)  r_state <= IDLE;
                    else if (done) r_state <= SEND_ACK;
                end
                SEND_ACK: begin
                    // Abort beats latch, latch beats watchdog.
                    if (!w_req_s) begin
                        r_state <= IDLE;
                    end else if (w_valid_s) begin
                        r_data  <= data_in;
                        r_state <= WAIT_RELEASE;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!w_req_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start    = (r_state == WAIT_CNT);
    assign notice   = (r_state == WAIT_CNT);
    assign ack      = (r_state == SEND_ACK) || (r_state == WAIT_RELEASE);
    assign data_out = r_data;

endmodule

// File: tb/tb_slave_control.sv
// Randomized scoreboard bench for slave_control: the sequencer predicts output
// edges with cycle stamps from the handshake timing rules; a monitor checks them.
module tb_slave_control;

    localparam int TB_TO = 20;

    localparam int START_R = 0;
    localparam int START_F = 1;
    localparam int ACK_R   = 2;
    localparam int ACK_F   = 3;
    localparam int DATA    = 4;
    localparam int ERR_R   = 5;
    localparam int ERR_F   = 6;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       request = 1'b0;
    logic       valid   = 1'b0;
    logic       done    = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       start;
    logic       ack;
    logic       notice;
    logic [7:0] data_out;
    logic       err;

    slave_control #(
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .request  (request),
        .valid    (valid),
        .data_in  (data_in),
        .done     (done),
        .start    (start),
        .ack      (ack),
        .notice   (notice),
        .data_out (data_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_data = 8'h00;
    bit         model_err  = 1'b0;
    bit         mon_en     = 1'b0;
    int         txn        = 0;

    function automatic string kname(int k);
        case (k)
            START_R: return "start_rise";
            START_F: return "start_fall";
            ACK_R:   return "ack_rise";
            ACK_F:   return "ack_fall";
            DATA:    return "data_change";
            ERR_R:   return "err_rise";
            default: return "err_fall";
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(int k, int c, logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic seen(int k, logic [7:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s data=%0h at cycle %0d, none expected",
                     kname(k), d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data !== d) begin
                bad++;
                $display("FAIL event: got %s data=%0h at cycle %0d, expected %s data=%0h at cycle %0d",
                         kname(k), d, cyc, kname(e.kind), e.data, e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge and reports every output change.
    logic       p_start = 1'b0;
    logic       p_ack   = 1'b0;
    logic       p_err   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("notice_eq_start", 32'(notice), 32'(start));
            if (start !== p_start)  seen(start ? START_R : START_F, 8'h00);
            if (ack !== p_ack)      seen(ack ? ACK_R : ACK_F, 8'h00);
            if (data_out !== p_data) seen(DATA, data_out);
            if (err !== p_err)      seen(err ? ERR_R : ERR_F, 8'h00);
            p_start = start;
            p_ack   = ack;
            p_data  = data_out;
            p_err   = err;
        end
    end

    // All stimulus is applied 2 time units after a rising edge.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // request rising before edge cyc+1: synchronised after +2, WAIT_CNT after +3.
    task automatic enter_wait();
        request = 1'b1;
        push(START_R, cyc + 3, 8'h00);
        step(3);
    endtask

    task automatic pulse_done_to_ack();
        done = 1'b1;
        push(START_F, cyc + 1, 8'h00);
        push(ACK_R,   cyc + 1, 8'h00);
        step(1);
        done = 1'b0;
    endtask

    task automatic t_normal(int dly, logic [7:0] d);
        $display("txn %0d: normal done_delay=%0d data=%02h", txn, dly, d);
        enter_wait();
        step(dly);
        pulse_done_to_ack();
        step($urandom_range(0, 4));
        valid   = 1'b1;
        data_in = d;
        if (d != model_data) push(DATA, cyc + 3, d);
        model_data = d;
        step(4);
        valid = 1'b0;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step($urandom_range(0, 3));
        request = 1'b0;
        push(ACK_F, cyc + 3, 8'h00);
        step(3 + $urandom_range(1, 3));
        chk("data_out_after_normal", 32'(data_out), 32'(model_data));
    endtask

    task automatic t_abort_wait(int dly);
        $display("txn %0d: abort in WAIT_CNT after %0d cycles", txn, dly);
        enter_wait();
        step(dly);
        request = 1'b0;
        push(START_F, cyc + 3, 8'h00);
        step(3 + $urandom_range(1, 3));
        chk("data_out_after_abort_wait", 32'(data_out), 32'(model_data));
    endtask

    task automatic t_abort_ack(logic [7:0] d);
        $display("txn %0d: abort in SEND_ACK with valid data=%02h", txn, d);
        enter_wait();
        step($urandom_range(1, 6));
        pulse_done_to_ack();
        step($urandom_range(0, 4));
        valid   = 1'b1;
        data_in = d;
        request = 1'b0;
        push(ACK_F, cyc + 3, 8'h00);
        step(4);
        valid = 1'b0;
        step($urandom_range(1, 3));
        chk("data_out_after_abort_ack", 32'(data_out), 32'(model_data));
    endtask

    task automatic t_spurious(logic [7:0] d);
        $display("txn %0d: spurious valid/done in IDLE data=%02h", txn, d);
        valid   = 1'b1;
        data_in = d;
        step(4);
        valid = 1'b0;
        done  = 1'b1;
        step(1);
        done = 1'b0;
        step(3);
        chk("start_after_spurious", 32'(start), 32'd0);
        chk("data_out_after_spurious", 32'(data_out), 32'(model_data));
    endtask

    task automatic do_reset(bit in_wait);
        #1;
        rst_n   = 1'b0;
        request = 1'b0;
        valid   = 1'b0;
        done    = 1'b0;
        #1;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_notice", 32'(notice), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        if (in_wait) push(START_F, cyc, 8'h00);
        if (model_data != 8'h00) push(DATA, cyc, 8'h00);
        if (model_err) push(ERR_F, cyc, 8'h00);
        model_data = 8'h00;
        model_err  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("idle_after_reset", 32'({start, ack}), 32'd0);
    endtask

    task automatic t_reset_mid();
        $display("txn %0d: reset in WAIT_CNT", txn);
        enter_wait();
        step($urandom_range(1, 5));
        do_reset(1'b1);
    endtask

    initial begin
        #1;
        chk("init_start", 32'(start), 32'd0);
        chk("init_notice", 32'(notice), 32'd0);
        chk("init_ack", 32'(ack), 32'd0);
        chk("init_data_out", 32'(data_out), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(2);

        txn++; t_normal(10, 8'hA5);
        txn++; t_abort_wait(5);
        txn++; t_abort_ack(8'h3C);
        txn++; t_spurious(8'h77);
        txn++; t_reset_mid();
        txn++; t_normal($urandom_range(1, 12), 8'($urandom));

        for (int i = 0; i < 30; i++) begin
            txn++;
            case ($urandom_range(0, 4))
                0, 1:    t_normal($urandom_range(1, 12), 8'($urandom));
                2:       t_abort_wait($urandom_range(1, 8));
                3:       t_abort_ack(8'($urandom));
                default: t_spurious(8'($urandom));
            endcase
        end

`ifdef SLAVE_TIMEOUT_EN
        begin
            int a;
            txn++;
            $display("txn %0d: SEND_ACK watchdog", txn);
            enter_wait();
            step($urandom_range(1, 6));
            pulse_done_to_ack();
            a = cyc;
            push(ACK_F,   a + TB_TO,     8'h00);
            push(ERR_R,   a + TB_TO,     8'h00);
            push(START_R, a + TB_TO + 1, 8'h00);
            model_err = 1'b1;
            step(TB_TO + 1);
            request = 1'b0;
            push(START_F, cyc + 3, 8'h00);
            step(5);
            chk("err_sticky", 32'(err), 32'd1);
            txn++; t_normal($urandom_range(1, 6), 8'($urandom));
            chk("err_still_set", 32'(err), 32'd1);
            txn++;
            $display("txn %0d: reset clears err", txn);
            do_reset(1'b0);
        end
`endif

        step(5);
        chk("err_final", 32'(err), 32'(model_err));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_control.md
# slave_control

Handshake controller for the Chip2Chip slave board. Synchronises the master's request/valid lines and drives the `start`/`done` pair of the one-second counter. Lights the leftmost LED for one second, then acknowledges the master and latches the transferred data for display. Sits between the inter-board pins and the counter/display logic in TOP_SLAVE.

## Interface
Parameters:
- `DATA_W`, 8: width of the transferred data word.
- `TIMEOUT_CYCLES`, 100000000: watchdog limit in SEND_ACK (used only with `SLAVE_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset. Asynchronous, active-low; all state clears immediately on assertion.
- `request`  in  1  master request. Asynchronous to `clk`.
- `valid`  in  1  master data-valid. Asynchronous to `clk`.
- `data_in`  in  DATA_W  master data. Stable while `valid` is high.
- `done`  in  1  from counter; one-cycle pulse after one second of `start`.
- `start`  out  1  to counter; high only in WAIT_CNT.
- `ack`  out  1  to master; high in SEND_ACK and WAIT_RELEASE.
- `notice`  out  1  leftmost LED; high only in WAIT_CNT.
- `data_out`  out  DATA_W  last latched word, to display.
- `err`  out  1  sticky timeout flag (0 constant without `SLAVE_TIMEOUT_EN`).

## Operation
- Synchronisation:
  - `request` and `valid` each pass through a 2-flop synchroniser, producing `req_s` and `valid_s`.
  - `data_in` is not synchronised. It is sampled only when `valid_s` is high, and is stable by then.
- FSM states:
  - IDLE: `req_s` → WAIT_CNT.
  - WAIT_CNT:
    - `!req_s` → IDLE (abort; `start` drop clears the counter).
    - Else `done` → SEND_ACK.
  - SEND_ACK:
    - `!req_s` → IDLE, with no latch. Abort wins over a simultaneous `valid_s`.
    - Else `valid_s` → latch `data_in` into `data_out`, go to WAIT_RELEASE.
  - WAIT_RELEASE: `!req_s` → IDLE.
- Outputs:
  - `start`, `ack` and `notice` are Moore outputs decoded from the registered state, so they are glitch-free.
  - `data_out` is registered and holds its value until the next latch.
- Input handling outside the listed states:
  - `valid_s` is ignored in IDLE, WAIT_CNT and WAIT_RELEASE.
  - `done` is ignored outside WAIT_CNT.
- Reset values: state IDLE; `start`, `ack`, `notice`, `err` = 0; `data_out` = 0; synchroniser flops = 0.

## Timing
- Request to WAIT_CNT:
  - `request` rising before clock edge 0 gives `req_s` high after edge 1.
  - The state is WAIT_CNT after edge 2, so `start` and `notice` are high from edge 2.
- `done` sampled high at edge N: SEND_ACK after edge N, so `ack` rises and `start` falls in the same cycle.
- `valid` rising before edge V: latch at edge V+2; `data_out` is updated after edge V+2.
- Release: `request` falling before edge R gives `ack` low after edge R+2 (via IDLE).
- New request: a `request` re-asserted while `ack` is still high is not seen as new. A new transaction starts only after a pass through IDLE.
- Reset mid-operation: outputs go to reset values asynchronously. The counter sees `start`=0 and clears on its own.

## Configuration
`SLAVE_TIMEOUT_EN`:
- Defined:
  - A cycle counter runs in SEND_ACK only and clears on leaving SEND_ACK.
  - Width is the minimal width holding `TIMEOUT_CYCLES`.
  - When the count reaches `TIMEOUT_CYCLES` with neither `valid_s` nor `!req_s`, the FSM goes to IDLE and `err` sets.
  - `err` clears only on `rst_n`. Abort and latch take priority over timeout on the same edge.
- Undefined: no timeout counter; SEND_ACK waits indefinitely; `err` is tied to 0.

## Structure
- Shared package `slave_pkg`: state encodings (IDLE=0, WAIT_CNT=1, SEND_ACK=2, WAIT_RELEASE=3, 2-bit), default `DATA_W`, default `TIMEOUT_CYCLES`.
- Sub-module `sync_2ff`: single-bit two-flop synchroniser with async active-low reset to 0. Instantiated twice.

## Test plan
The bench drives `done` from a stub in place of the real counter.
- Normal transaction:
  - Stimulus: raise `request`; stub pulses `done` 10 cycles after `start` rises; then `valid`=1 with `data_in`=8'hA5; then drop `request`.
  - Required: `start`/`notice` high 2 cycles after `request`; `ack` high the cycle after `done`; `data_out`=8'hA5 2 cycles after `valid`; `ack` low 2 cycles after `request` falls.
- Abort in WAIT_CNT: drop `request` 5 cycles after `start` rises → `start`/`notice` low 2 cycles later, `ack` never rises, `data_out` unchanged.
- Abort in SEND_ACK with `valid`/`request` toggled the same cycle: `valid`=1 (`data_in`=8'h3C) and `request`=0 together → IDLE, `data_out` keeps its previous value.
- Reset mid-operation: assert `rst_n`=0 between clock edges in WAIT_CNT → `start`, `notice`, `ack` = 0 immediately (before the next edge); state IDLE after release.
- Spurious inputs: `valid` pulse in IDLE and `done` pulse in WAIT_RELEASE → no state change, `data_out` unchanged.
- Timeout (`SLAVE_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=20): enter SEND_ACK and hold `request` with no `valid` → IDLE after 20 cycles, `err`=1 and stays 1 until reset.
